// File: rtl/mul_datapath.sv
// Datapath for the repeated-addition multiplier: operand A, down-counting B, accumulator P,
// and a valid/ready output register that captures P on the FSM's done edge.
module mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               ldA,
  input  logic               ldB,
  input  logic               ldP,
  input  logic               clrP,
  input  logic               decB,
  input  logic               done,
  output logic               eqz,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [WIDTH-1:0]   add_count,
  output logic               result_lost
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    p_reg;
  logic             done_d;
  logic             capture;
  logic             do_add;
  logic             do_dec;

  assign eqz     = (b_reg == '0);
  assign do_add  = ldP && !eqz;
  assign do_dec  = decB && !eqz;
  assign capture = done && !done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
    end else if (ldA) begin
      a_reg <= a_in;
    end
  end

  // Load wins over decrement; B saturates at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg <= '0;
    end else if (ldB) begin
      b_reg <= b_in;
    end else if (do_dec) begin
      b_reg <= b_reg - ONE_W;
    end
  end

  // The FSM issues one extra ldP while it samples eqz; gating on !eqz absorbs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg     <= '0;
      add_count <= '0;
    end else if (clrP) begin
      p_reg     <= '0;
      add_count <= '0;
    end else if (do_add) begin
      p_reg     <= p_reg + {{WIDTH{1'b0}}, a_reg};
      add_count <= add_count + ONE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d <= 1'b0;
    end else begin
      done_d <= done;
    end
  end

  // A new capture takes precedence over an accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product     <= '0;
      prod_valid  <= 1'b0;
      result_lost <= 1'b0;
    end else if (capture) begin
      product    <= p_reg;
      prod_valid <= 1'b1;
      if (prod_valid && !prod_ready) begin
        result_lost <= 1'b1;
      end
    end else if (prod_valid && prod_ready) begin
      prod_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: emulates the multiplier FSM strobes and
// scoreboards captured products against table-driven expectations.
module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        ldA = 1'b0, ldB = 1'b0, ldP = 1'b0, clrP = 1'b0, decB = 1'b0, done = 1'b0;
  logic        eqz;
  logic [31:0] product;
  logic        prod_valid;
  logic        prod_ready = 1'b0;
  logic [15:0] add_count;
  logic        result_lost;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_prod;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] prod;
    logic [15:0] cnt;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[7];

  mul_datapath #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .b_in        (b_in),
    .ldA         (ldA),
    .ldB         (ldB),
    .ldP         (ldP),
    .clrP        (clrP),
    .decB        (decB),
    .done        (done),
    .eqz         (eqz),
    .product     (product),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .add_count   (add_count),
    .result_lost (result_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FSM emulation: load, clear, B accumulate cycles plus one absorbed eqz-sample
  // cycle, then raise done. Leaves the product unaccepted.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] ep, input logic [15:0] ec,
                         input logic pv_before, input string tag);
    sb_t exp_item;
    sb_t got_item;
    ldA = 1'b1; ldB = 1'b1; a_in = a; b_in = b;
    tick();
    ldA = 1'b0; ldB = 1'b0;
    chk({tag, "_eqz_after_load"}, 64'(eqz), 64'(b == 16'd0));
    clrP = 1'b1;
    tick();
    clrP = 1'b0;
    ldP = 1'b1; decB = 1'b1;
    for (int i = 0; i <= int'(b); i++) tick();
    ldP = 1'b0; decB = 1'b0;
    chk({tag, "_eqz_end"}, 64'(eqz), 64'd1);
    done = 1'b1;
    exp_item.prod = ep;
    exp_item.cnt  = ec;
    sb_q.push_back(exp_item);
    chk({tag, "_pv_at_done_edge"}, 64'(prod_valid), 64'(pv_before));
    tick();
    chk({tag, "_pv_after_done"}, 64'(prod_valid), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      got_item = sb_q.pop_front();
      chk({tag, "_product"}, 64'(product), 64'(got_item.prod));
      chk({tag, "_add_count"}, 64'(add_count), 64'(got_item.cnt));
    end
    tick();
    chk({tag, "_product_held"}, 64'(product), 64'(ep));
    done = 1'b0;
    tick();
  endtask

  task automatic accept(input string tag);
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    chk({tag, "_pv_after_accept"}, 64'(prod_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'd7,     16'd5,   32'd35,          16'd5};
    vecs[1] = '{16'd9,     16'd0,   32'd0,           16'd0};
    vecs[2] = '{16'hFFFF,  16'd3,   32'h0002_FFFD,   16'd3};
    vecs[3] = '{16'd2,     16'd3,   32'd6,           16'd3};
    vecs[4] = '{16'd0,     16'd9,   32'd0,           16'd9};
    vecs[5] = '{16'd300,   16'd200, 32'd60000,       16'd200};
    vecs[6] = '{16'hFFFF,  16'd15,  32'h000E_FFF1,   16'd15};

    #2;
    chk("rst_eqz", 64'(eqz), 64'd1);
    chk("rst_pv", 64'(prod_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_count", 64'(add_count), 64'd0);
    chk("rst_lost", 64'(result_lost), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].exp_prod, vecs[i].exp_cnt, 1'b0,
              $sformatf("vec%0d", i));
      accept($sformatf("vec%0d", i));
    end
    chk("lost_still_clear", 64'(result_lost), 64'd0);

    // Overwrite an unaccepted product.
    run_mul(16'd7, 16'd5, 32'd35, 16'd5, 1'b0, "lost_first");
    chk("lost_before_second", 64'(result_lost), 64'd0);
    run_mul(16'd2, 16'd3, 32'd6, 16'd3, 1'b1, "lost_second");
    chk("lost_set", 64'(result_lost), 64'd1);
    chk("lost_product", 64'(product), 64'd6);
    accept("lost");
    chk("lost_sticky", 64'(result_lost), 64'd1);

    // ldB beats decB: load 1 over a decrement of 3.
    clrP = 1'b1; ldB = 1'b1; b_in = 16'd3;
    tick();
    clrP = 1'b0; b_in = 16'd1; decB = 1'b1;
    tick();
    ldB = 1'b0;
    chk("ldb_prio_eqz", 64'(eqz), 64'd0);
    tick();
    chk("ldb_prio_dec_to_zero", 64'(eqz), 64'd1);
    tick();
    decB = 1'b0;
    chk("b_no_wrap", 64'(eqz), 64'd1);
    ldP = 1'b1;
    tick();
    ldP = 1'b0;
    chk("ldp_eqz_absorbed", 64'(add_count), 64'd0);

    // clrP beats ldP.
    ldA = 1'b1; a_in = 16'd4; ldB = 1'b1; b_in = 16'd5;
    tick();
    ldA = 1'b0; ldB = 1'b0; ldP = 1'b1;
    tick();
    chk("one_add", 64'(add_count), 64'd1);
    clrP = 1'b1;
    tick();
    clrP = 1'b0; ldP = 1'b0;
    chk("clrp_prio_count", 64'(add_count), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("clrp_prio_pv", 64'(prod_valid), 64'd1);
    chk("clrp_prio_product", 64'(product), 64'd0);
    tick();
    accept("clrp");

    // Asynchronous reset mid-accumulate with B=2.
    ldA = 1'b1; a_in = 16'd5; ldB = 1'b1; b_in = 16'd4;
    tick();
    ldA = 1'b0; ldB = 1'b0; clrP = 1'b1;
    tick();
    clrP = 1'b0; ldP = 1'b1; decB = 1'b1;
    tick();
    tick();
    chk("mid_count", 64'(add_count), 64'd2);
    chk("mid_eqz", 64'(eqz), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_eqz", 64'(eqz), 64'd1);
    chk("arst_count", 64'(add_count), 64'd0);
    chk("arst_product", 64'(product), 64'd0);
    chk("arst_pv", 64'(prod_valid), 64'd0);
    chk("arst_lost", 64'(result_lost), 64'd0);
    ldP = 1'b0; decB = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_pv", 64'(prod_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
